// File: rtl/id_lifecycle_tracker_pkg.sv
// ---------------------------------------------------------------------------
// id_lifecycle_tracker_pkg
//   Shared definitions for the instruction-ID lifecycle tracker.
//   - Default parameter values for the tracker and its sub-blocks.
//   - Statistics counter width and type.
// No ports (package).
// ---------------------------------------------------------------------------
package id_lifecycle_tracker_pkg;

  localparam int unsigned TRK_NUM_IDS_DEF      = 8;
  localparam int unsigned TRK_RETIRE_PORTS_DEF = 2;
  localparam int unsigned TRK_WB_PORTS_DEF     = 3;
  localparam int unsigned TRK_MAX_RD_DEF       = 1;

  localparam int unsigned STAT_W = 32;
  typedef logic [STAT_W-1:0] stat_cnt_t;

endpackage

// File: rtl/id_lifecycle_tracker_pending_set.sv
// ---------------------------------------------------------------------------
// id_pending_set
//   One pending bit per instruction ID. A bit is set when a multicycle
//   instruction issues and cleared when that ID completes on a writeback
//   port. RD_PORTS combinational read ports expose the bits of the IDs the
//   retire logic is looking at this cycle.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears all bits)
//   set_en/set_id set pending for one ID
//   clr_valid     per-writeback-port clear strobe
//   clr_ids       packed clear IDs, port k at [k*IDW +: IDW]
//   rd_ids        packed read IDs, port i at [i*IDW +: IDW]
//   rd_pending    pending bit for each read port
// ---------------------------------------------------------------------------
module id_pending_set
  import id_lifecycle_tracker_pkg::*;
#(
  parameter  int unsigned NUM_IDS  = TRK_NUM_IDS_DEF,
  parameter  int unsigned WB_PORTS = TRK_WB_PORTS_DEF,
  parameter  int unsigned RD_PORTS = TRK_RETIRE_PORTS_DEF,
  localparam int unsigned IDW      = $clog2(NUM_IDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_en,
  input  logic [IDW-1:0]          set_id,
  input  logic [WB_PORTS-1:0]     clr_valid,
  input  logic [WB_PORTS*IDW-1:0] clr_ids,
  input  logic [RD_PORTS*IDW-1:0] rd_ids,
  output logic [RD_PORTS-1:0]     rd_pending
);

  logic [NUM_IDS-1:0] pending_q, pending_d;

  always_comb begin
    pending_d = pending_q;
    for (int k = 0; k < WB_PORTS; k++) begin
      if (clr_valid[k]) pending_d[clr_ids[k*IDW +: IDW]] = 1'b0;
    end
    if (set_en) pending_d[set_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  always_comb begin
    rd_pending = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_pending[i] = pending_q[rd_ids[i*IDW +: IDW]];
    end
  end

  // A completion must target an outstanding multicycle ID, and an ID cannot
  // be both issued and completed in the same cycle.
  for (genvar k = 0; k < WB_PORTS; k++) begin : g_chk
    a_wb_pending: assert property (@(posedge clk) disable iff (rst)
      clr_valid[k] |-> pending_q[clr_ids[k*IDW +: IDW]]);
    a_set_clr: assert property (@(posedge clk) disable iff (rst)
      (set_en && clr_valid[k]) |-> (clr_ids[k*IDW +: IDW] != set_id));
  end

endmodule

// File: rtl/id_lifecycle_tracker.sv
// ---------------------------------------------------------------------------
// id_lifecycle_tracker
//   In-order instruction-ID allocator/retirer. IDs move through
//   fetch (alloc) -> issue -> out-of-order writeback -> in-order retire.
//   Three wrapping pointers (alloc, issue, retire) and two occupancy counts
//   (pre-issue, post-issue) describe the ring of IDs. Up to RETIRE_PORTS
//   oldest post-issue IDs retire per cycle, at most MAX_RD_RETIRES of which
//   may write a register. Retire outputs are registered (1-cycle latency).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   alloc/alloc_ready/alloc_id       fetch-side allocation handshake
//   issue/issue_id/issue_uses_rd/issue_multicycle  issue of oldest pre-issue ID
//   fetch_flush               drop all pre-issue IDs
//   wb_valid/wb_id            multicycle completion ports
//   retire_hold               block retirement
//   exception_pending         retire through port 0 only
//   retire_valid/ids/count/rd_count  registered retire result
//   pre_issue_count/post_issue_count occupancy
//   stat_full_cycles/stat_rd_limit_cycles  statistics
//
// Build option: define ID_TRACKER_STATS_EN to build the two saturating
// statistics counters; otherwise both stat ports read 0.
// ---------------------------------------------------------------------------
module id_lifecycle_tracker
  import id_lifecycle_tracker_pkg::*;
#(
  parameter  int unsigned NUM_IDS        = TRK_NUM_IDS_DEF,
  parameter  int unsigned RETIRE_PORTS   = TRK_RETIRE_PORTS_DEF,
  parameter  int unsigned WB_PORTS       = TRK_WB_PORTS_DEF,
  parameter  int unsigned MAX_RD_RETIRES = TRK_MAX_RD_DEF,
  localparam int unsigned IDW            = $clog2(NUM_IDS),
  localparam int unsigned CNTW           = IDW + 1,
  localparam int unsigned RCW            = $clog2(RETIRE_PORTS + 1),
  localparam int unsigned RDW            = $clog2(MAX_RD_RETIRES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc,
  output logic                        alloc_ready,
  output logic [IDW-1:0]              alloc_id,
  input  logic                        issue,
  output logic [IDW-1:0]              issue_id,
  input  logic                        issue_uses_rd,
  input  logic                        issue_multicycle,
  input  logic                        fetch_flush,
  input  logic [WB_PORTS-1:0]         wb_valid,
  input  logic [WB_PORTS*IDW-1:0]     wb_id,
  input  logic                        retire_hold,
  input  logic                        exception_pending,
  output logic [RETIRE_PORTS-1:0]     retire_valid,
  output logic [RETIRE_PORTS*IDW-1:0] retire_ids,
  output logic [RCW-1:0]              retire_count,
  output logic [RDW-1:0]              retire_rd_count,
  output logic [CNTW-1:0]             pre_issue_count,
  output logic [CNTW-1:0]             post_issue_count,
  output stat_cnt_t                   stat_full_cycles,
  output stat_cnt_t                   stat_rd_limit_cycles
);

  localparam int unsigned SUMW = CNTW + 1;

  typedef struct packed {
    logic [RETIRE_PORTS-1:0]     valid;
    logic [RETIRE_PORTS*IDW-1:0] ids;
    logic [RCW-1:0]              count;
    logic [RDW-1:0]              rd_count;
  } id_tracker_retire_t;

  function automatic logic [RETIRE_PORTS*IDW-1:0] reset_ids();
    logic [RETIRE_PORTS*IDW-1:0] v;
    v = '0;
    for (int i = 0; i < RETIRE_PORTS; i++) v[i*IDW +: IDW] = IDW'(i);
    return v;
  endfunction

  logic [IDW-1:0]              alloc_ptr_q, alloc_ptr_d;
  logic [IDW-1:0]              issue_ptr_q, issue_ptr_d;
  logic [IDW-1:0]              retire_ptr_q, retire_ptr_d;
  logic [CNTW-1:0]             pre_q, pre_d;
  logic [CNTW-1:0]             post_q, post_d;
  logic [NUM_IDS-1:0]          uses_rd_q, uses_rd_d;
  id_tracker_retire_t          ret_q, ret_d;

  logic [RETIRE_PORTS*IDW-1:0] port_ids;
  logic [RETIRE_PORTS-1:0]     pend_rd;
  logic [RETIRE_PORTS-1:0]     r_valid;
  logic [RCW-1:0]              r_cnt;
  logic [RDW-1:0]              r_rd_cnt;
  logic                        rd_stop;

  assign alloc_ready = (SUMW'(pre_q) + SUMW'(post_q)) < SUMW'(NUM_IDS);
  assign alloc_id    = alloc_ptr_q;
  assign issue_id    = issue_ptr_q;

  always_comb begin
    port_ids = '0;
    for (int i = 0; i < RETIRE_PORTS; i++) begin
      port_ids[i*IDW +: IDW] = retire_ptr_q + IDW'(i);
    end
  end

  id_pending_set #(
    .NUM_IDS  (NUM_IDS),
    .WB_PORTS (WB_PORTS),
    .RD_PORTS (RETIRE_PORTS)
  ) u_pending (
    .clk        (clk),
    .rst        (rst),
    .set_en     (issue && issue_multicycle),
    .set_id     (issue_ptr_q),
    .clr_valid  (wb_valid),
    .clr_ids    (wb_id),
    .rd_ids     (port_ids),
    .rd_pending (pend_rd)
  );

  // Retire decision. A port retires only if every older port retires, so
  // the first blocked port (for any reason) ends the group. rd_stop marks a
  // group whose only obstacle was the rd-writing retirement limit.
  always_comb begin
    logic chain;
    logic base_ok;
    logic rd_ok;
    logic cur_rd;
    r_valid  = '0;
    r_cnt    = '0;
    r_rd_cnt = '0;
    rd_stop  = 1'b0;
    chain    = 1'b1;
    base_ok  = 1'b0;
    rd_ok    = 1'b0;
    cur_rd   = 1'b0;
    for (int i = 0; i < RETIRE_PORTS; i++) begin
      cur_rd  = uses_rd_q[port_ids[i*IDW +: IDW]];
      base_ok = chain && (post_q > CNTW'(i)) && !pend_rd[i] && !retire_hold &&
                ((i == 0) || !exception_pending);
      rd_ok   = !cur_rd || (r_rd_cnt < RDW'(MAX_RD_RETIRES));
      if (base_ok && !rd_ok) rd_stop = 1'b1;
      r_valid[i] = base_ok && rd_ok;
      if (r_valid[i]) begin
        r_cnt = r_cnt + RCW'(1);
        if (cur_rd) r_rd_cnt = r_rd_cnt + RDW'(1);
      end
      chain = r_valid[i];
    end
  end

  // A flush restarts allocation right behind the issue point, so the ID
  // issuing this cycle (if any) is kept and any concurrent alloc is dropped.
  always_comb begin
    if (fetch_flush) begin
      alloc_ptr_d = issue_ptr_q + IDW'(issue);
      pre_d       = '0;
    end else begin
      alloc_ptr_d = alloc_ptr_q + IDW'(alloc);
      pre_d       = pre_q + CNTW'(alloc) - CNTW'(issue);
    end
    issue_ptr_d  = issue_ptr_q + IDW'(issue);
    // The ID issuing this cycle is not yet in post_q, so it cannot retire now.
    post_d       = post_q + CNTW'(issue) - CNTW'(r_cnt);
    retire_ptr_d = retire_ptr_q + IDW'(r_cnt);

    uses_rd_d = uses_rd_q;
    if (issue) uses_rd_d[issue_ptr_q] = issue_uses_rd;

    ret_d.valid    = r_valid;
    ret_d.ids      = port_ids;
    ret_d.count    = r_cnt;
    ret_d.rd_count = r_rd_cnt;
  end

  // ---- register boundary: tracker state and retire outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr_q    <= '0;
      issue_ptr_q    <= '0;
      retire_ptr_q   <= '0;
      pre_q          <= '0;
      post_q         <= '0;
      ret_q.valid    <= '0;
      ret_q.ids      <= reset_ids();
      ret_q.count    <= '0;
      ret_q.rd_count <= '0;
    end else begin
      alloc_ptr_q  <= alloc_ptr_d;
      issue_ptr_q  <= issue_ptr_d;
      retire_ptr_q <= retire_ptr_d;
      pre_q        <= pre_d;
      post_q       <= post_d;
      ret_q        <= ret_d;
    end
  end

  // uses_rd is always written at issue before it is read at retire.
  always_ff @(posedge clk) begin
    uses_rd_q <= uses_rd_d;
  end

  assign retire_valid     = ret_q.valid;
  assign retire_ids       = ret_q.ids;
  assign retire_count     = ret_q.count;
  assign retire_rd_count  = ret_q.rd_count;
  assign pre_issue_count  = pre_q;
  assign post_issue_count = post_q;

`ifdef ID_TRACKER_STATS_EN
  function automatic stat_cnt_t sat_inc(input stat_cnt_t v, input logic en);
    return (en && (v != '1)) ? v + stat_cnt_t'(1) : v;
  endfunction

  stat_cnt_t full_cyc_q, full_cyc_d;
  stat_cnt_t rd_lim_q, rd_lim_d;

  always_comb begin
    full_cyc_d = sat_inc(full_cyc_q, !alloc_ready);
    rd_lim_d   = sat_inc(rd_lim_q, rd_stop);
  end

  // ---- register boundary: statistics ----
  always_ff @(posedge clk) begin
    if (rst) begin
      full_cyc_q <= '0;
      rd_lim_q   <= '0;
    end else begin
      full_cyc_q <= full_cyc_d;
      rd_lim_q   <= rd_lim_d;
    end
  end

  assign stat_full_cycles     = full_cyc_q;
  assign stat_rd_limit_cycles = rd_lim_q;
`else
  // The rd-limit flag only feeds the statistics counters.
  logic stats_unused;
  assign stats_unused         = rd_stop;
  assign stat_full_cycles     = '0;
  assign stat_rd_limit_cycles = '0;
`endif

  a_alloc_ready: assert property (@(posedge clk) disable iff (rst)
    alloc |-> alloc_ready);
  a_issue_nonempty: assert property (@(posedge clk) disable iff (rst)
    issue |-> (pre_q != '0));

endmodule

// File: tb/tb_id_lifecycle_tracker.sv
module tb_id_lifecycle_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc, issue, issue_uses_rd, issue_multicycle, fetch_flush;
  logic [2:0] wb_valid;
  logic [8:0] wb_id;
  logic       retire_hold, exception_pending;

  // DUT 1: MAX_RD_RETIRES = 1
  logic        alloc_ready1;
  logic [2:0]  alloc_id1, issue_id1;
  logic [1:0]  ret_valid1;
  logic [5:0]  ret_ids1;
  logic [1:0]  ret_count1;
  logic [0:0]  ret_rd1;
  logic [3:0]  pre1, post1;
  logic [31:0] stat_full1, stat_rd1;

  // DUT 2: MAX_RD_RETIRES = 2
  logic        alloc_ready2;
  logic [2:0]  alloc_id2, issue_id2;
  logic [1:0]  ret_valid2;
  logic [5:0]  ret_ids2;
  logic [1:0]  ret_count2;
  logic [1:0]  ret_rd2;
  logic [3:0]  pre2, post2;
  logic [31:0] stat_full2, stat_rd2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int         due;
    int         which;
    logic [1:0] vld;
    logic [2:0] id0;
    logic [2:0] id1;
    int         cnt;
    int         rd;
  } ret_exp_t;

  ret_exp_t q1[$];
  ret_exp_t q2[$];

  always #5 clk = ~clk;

  id_lifecycle_tracker #(
    .NUM_IDS(8), .RETIRE_PORTS(2), .WB_PORTS(3), .MAX_RD_RETIRES(1)
  ) u_dut1 (
    .clk(clk), .rst(rst),
    .alloc(alloc), .alloc_ready(alloc_ready1), .alloc_id(alloc_id1),
    .issue(issue), .issue_id(issue_id1), .issue_uses_rd(issue_uses_rd),
    .issue_multicycle(issue_multicycle), .fetch_flush(fetch_flush),
    .wb_valid(wb_valid), .wb_id(wb_id),
    .retire_hold(retire_hold), .exception_pending(exception_pending),
    .retire_valid(ret_valid1), .retire_ids(ret_ids1),
    .retire_count(ret_count1), .retire_rd_count(ret_rd1),
    .pre_issue_count(pre1), .post_issue_count(post1),
    .stat_full_cycles(stat_full1), .stat_rd_limit_cycles(stat_rd1)
  );

  id_lifecycle_tracker #(
    .NUM_IDS(8), .RETIRE_PORTS(2), .WB_PORTS(3), .MAX_RD_RETIRES(2)
  ) u_dut2 (
    .clk(clk), .rst(rst),
    .alloc(alloc), .alloc_ready(alloc_ready2), .alloc_id(alloc_id2),
    .issue(issue), .issue_id(issue_id2), .issue_uses_rd(issue_uses_rd),
    .issue_multicycle(issue_multicycle), .fetch_flush(fetch_flush),
    .wb_valid(wb_valid), .wb_id(wb_id),
    .retire_hold(retire_hold), .exception_pending(exception_pending),
    .retire_valid(ret_valid2), .retire_ids(ret_ids2),
    .retire_count(ret_count2), .retire_rd_count(ret_rd2),
    .pre_issue_count(pre2), .post_issue_count(post2),
    .stat_full_cycles(stat_full2), .stat_rd_limit_cycles(stat_rd2)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_cmp(input ret_exp_t e);
    logic [1:0] v;
    logic [5:0] ids;
    int         c;
    int         r;
    string      p;
    if (e.which == 1) begin
      v = ret_valid1; ids = ret_ids1; c = int'(ret_count1); r = int'(ret_rd1);
    end else begin
      v = ret_valid2; ids = ret_ids2; c = int'(ret_count2); r = int'(ret_rd2);
    end
    p = $sformatf("dut%0d.cyc%0d", e.which, e.due);
    check_val({p, ".retire_valid"}, 32'(v), 32'(e.vld));
    check_val({p, ".retire_count"}, 32'(c), 32'(e.cnt));
    check_val({p, ".retire_rd_count"}, 32'(r), 32'(e.rd));
    if (e.vld[0]) check_val({p, ".retire_id0"}, 32'(ids[2:0]), 32'(e.id0));
    if (e.vld[1]) check_val({p, ".retire_id1"}, 32'(ids[5:3]), 32'(e.id1));
  endtask

  // Expected registered retire result for the cycle about to be driven.
  task automatic exp_ret(input int which, input logic [1:0] vld, input int id0,
                         input int id1, input int cnt, input int rd);
    ret_exp_t e;
    e.due = cyc + 1; e.which = which; e.vld = vld;
    e.id0 = 3'(id0); e.id1 = 3'(id1); e.cnt = cnt; e.rd = rd;
    if (which == 1) q1.push_back(e);
    else            q2.push_back(e);
  endtask

  task automatic tick();
    ret_exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (q1.size() != 0 && q1[0].due <= cyc) begin
      e = q1.pop_front();
      sb_cmp(e);
    end
    while (q2.size() != 0 && q2[0].due <= cyc) begin
      e = q2.pop_front();
      sb_cmp(e);
    end
  endtask

  task automatic step(input logic a, input logic i, input logic rd, input logic mc,
                      input logic fl, input logic hold, input logic exc);
    alloc = a; issue = i; issue_uses_rd = rd; issue_multicycle = mc;
    fetch_flush = fl; retire_hold = hold; exception_pending = exc;
    tick();
    alloc = 1'b0; issue = 1'b0; issue_uses_rd = 1'b0; issue_multicycle = 1'b0;
    fetch_flush = 1'b0; retire_hold = 1'b0; exception_pending = 1'b0;
    wb_valid = '0; wb_id = '0;
  endtask

  task automatic idle_exp0();
    exp_ret(1, 2'b00, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    alloc = 1'b0; issue = 1'b0; issue_uses_rd = 1'b0; issue_multicycle = 1'b0;
    fetch_flush = 1'b0; wb_valid = '0; wb_id = '0;
    retire_hold = 1'b0; exception_pending = 1'b0;
    repeat (2) tick();

    // Reset state
    check_val("rst.retire_valid", 32'(ret_valid1), 32'd0);
    check_val("rst.retire_count", 32'(ret_count1), 32'd0);
    check_val("rst.retire_rd_count", 32'(ret_rd1), 32'd0);
    check_val("rst.retire_ids", 32'(ret_ids1), 32'(6'b001_000));
    check_val("rst.alloc_ready", 32'(alloc_ready1), 32'd1);
    check_val("rst.alloc_id", 32'(alloc_id1), 32'd0);
    check_val("rst.pre", 32'(pre1), 32'd0);
    check_val("rst.post", 32'(post1), 32'd0);
    rst = 1'b0;

    // Fill all 8 IDs
    for (int k = 0; k < 8; k++) begin
      check_val($sformatf("fill.alloc_id%0d", k), 32'(alloc_id1), 32'(k));
      check_val($sformatf("fill.alloc_ready%0d", k), 32'(alloc_ready1), 32'd1);
      exp_ret(1, 2'b00, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
    end
    check_val("full.alloc_ready", 32'(alloc_ready1), 32'd0);
    check_val("full.pre", 32'(pre1), 32'd8);
    check_val("full.post", 32'(post1), 32'd0);

    // Three single-cycle, no-rd issues under retire_hold, then release
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("t2.issue_id%0d", k), 32'(issue_id1), 32'(k));
      exp_ret(1, 2'b00, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 1, 0);
    end
    check_val("t2.post3", 32'(post1), 32'd3);
    check_val("t2.pre5", 32'(pre1), 32'd5);
    exp_ret(1, 2'b11, 0, 1, 2, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    exp_ret(1, 2'b01, 2, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    idle_exp0();
    check_val("t2.post0", 32'(post1), 32'd0);
    check_val("t2.alloc_ready", 32'(alloc_ready1), 32'd1);
    check_val("t2.alloc_id_wrap", 32'(alloc_id1), 32'd0);

    // Two rd-writing issues (IDs 3,4): limit 1 vs limit 2
    for (int k = 3; k < 5; k++) begin
      check_val($sformatf("t3.issue_id%0d", k), 32'(issue_id1), 32'(k));
      exp_ret(1, 2'b00, 0, 0, 0, 0);
      exp_ret(2, 2'b00, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 1, 0);
    end
    exp_ret(1, 2'b01, 3, 0, 1, 1);
    exp_ret(2, 2'b11, 3, 4, 2, 2);
    step(0, 0, 0, 0, 0, 0, 0);
    exp_ret(1, 2'b01, 4, 0, 1, 1);
    exp_ret(2, 2'b00, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    exp_ret(1, 2'b00, 0, 0, 0, 0);
    exp_ret(2, 2'b00, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check_val("t3.post_dut1", 32'(post1), 32'd0);
    check_val("t3.post_dut2", 32'(post2), 32'd0);

    // ID5 multicycle, ID6 single-cycle with rd; wb for ID5 five cycles later
    check_val("t4.issue_id5", 32'(issue_id1), 32'd5);
    exp_ret(1, 2'b00, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    exp_ret(1, 2'b00, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    repeat (3) idle_exp0();
    wb_valid = 3'b100;
    wb_id    = {3'd5, 3'd0, 3'd0};
    idle_exp0();
    exp_ret(1, 2'b11, 5, 6, 2, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    idle_exp0();
    check_val("t4.post0", 32'(post1), 32'd0);
    check_val("t4.pre1", 32'(pre1), 32'd1);

    // 4 allocated, 1 issued, then flush with a simultaneous alloc
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("t5.alloc_id%0d", k), 32'(alloc_id1), 32'(k));
      exp_ret(1, 2'b00, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1, 0);
    end
    check_val("t5.pre4", 32'(pre1), 32'd4);
    check_val("t5.issue_id7", 32'(issue_id1), 32'd7);
    exp_ret(1, 2'b00, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    check_val("t5.alloc_id3", 32'(alloc_id1), 32'd3);
    exp_ret(1, 2'b00, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 0);
    check_val("t5.flush_pre", 32'(pre1), 32'd0);
    check_val("t5.flush_alloc_id", 32'(alloc_id1), 32'd0);
    check_val("t5.flush_post", 32'(post1), 32'd1);
    check_val("t5.flush_issue_id", 32'(issue_id1), 32'd0);
    exp_ret(1, 2'b01, 7, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check_val("t5.post0", 32'(post1), 32'd0);

    // exception_pending: port 0 only
    for (int k = 0; k < 2; k++) begin
      exp_ret(1, 2'b00, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
    end
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("t6.issue_id%0d", k), 32'(issue_id1), 32'(k));
      exp_ret(1, 2'b00, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 1, 0);
    end
    exp_ret(1, 2'b01, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    exp_ret(1, 2'b01, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle_exp0();
    check_val("t6.post0", 32'(post1), 32'd0);
    check_val("t6.pre0", 32'(pre1), 32'd0);

    // Final state of the second instance
    check_val("end.dut2.alloc_id", 32'(alloc_id2), 32'd2);
    check_val("end.dut2.issue_id", 32'(issue_id2), 32'd2);
    check_val("end.dut2.alloc_ready", 32'(alloc_ready2), 32'd1);
    check_val("end.dut2.pre", 32'(pre2), 32'd0);
    check_val("end.dut2.post", 32'(post2), 32'd0);
`ifndef ID_TRACKER_STATS_EN
    check_val("end.stat_full", stat_full1, 32'd0);
    check_val("end.stat_rd", stat_rd1, 32'd0);
    check_val("end.dut2.stat_full", stat_full2, 32'd0);
    check_val("end.dut2.stat_rd", stat_rd2, 32'd0);
`endif
    check_val("end.sb1_drained", 32'(q1.size()), 32'd0);
    check_val("end.sb2_drained", 32'(q2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
